// File: rtl/common_pkg.sv
// Shared NoC defaults and flit layout helpers.
// A flit is packed as {last, addr[A_W-1:0], data[D_W-1:0]}, with last in the MSB.
package common_pkg;

    localparam int DEFAULT_VC_W          = 2;
    localparam int DEFAULT_D_W           = 32;
    localparam int DEFAULT_A_W           = 8;
    localparam int DEFAULT_VC_FIFO_DEPTH = 4;

    function automatic int flit_w(input int a_w, input int d_w);
        return a_w + d_w + 1;
    endfunction

endpackage

// File: rtl/noc_if.sv
// Credit link between a NoC transmitter and its credit receiver.
interface noc_if
    import common_pkg::*;
#(
    parameter int VC_W = DEFAULT_VC_W,
    parameter int A_W  = DEFAULT_A_W,
    parameter int D_W  = DEFAULT_D_W
);

    logic [VC_W-1:0]  credit_vc_target;
    logic [A_W+D_W:0] credit_packet;
    logic [VC_W-1:0]  credit_vc_credit_gnt;

    modport transmitter (
        output credit_vc_target,
        output credit_packet,
        input  credit_vc_credit_gnt
    );

    modport receiver (
        input  credit_vc_target,
        input  credit_packet,
        output credit_vc_credit_gnt
    );

endinterface

// File: rtl/credit_bp_tx_chk.sv
// Protocol checker for the credit transmitter.
// It holds only assertions and has no effect on the logic.
module credit_bp_tx_chk #(
    parameter int VC_W  = 2,
    parameter int CNT_W = 2,
    parameter int DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    input logic [VC_W-1:0]       acc,
    input logic [VC_W-1:0]       gnt,
    input logic [VC_W*CNT_W-1:0] cnt,
    input logic [VC_W-1:0]       target,
    input logic [VC_W-1:0]       o_b
);

    for (genvar ii = 0; ii < VC_W; ii++) begin : g_vc
        a_no_acc_at_zero: assert property (@(posedge clk) disable iff (rst)
            !(acc[ii] && (cnt[ii*CNT_W +: CNT_W] == CNT_W'(0))));
        a_no_gnt_at_full: assert property (@(posedge clk) disable iff (rst)
            !(gnt[ii] && (cnt[ii*CNT_W +: CNT_W] == CNT_W'(DEPTH - 1))));
    end

    a_target_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(target));
    a_outputs_known:  assert property (@(posedge clk) disable iff (rst) !$isunknown({o_b, target}));

endmodule

// File: rtl/credit_bp_tx_rr_arbiter.sv
// Round-robin arbiter with a one-hot grant.
// The priority pointer moves to the winner only when the grant is consumed.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] w_win;
    logic [N-1:0]     w_gnt;

    // Scan the requests starting one past the previous winner.
    always_comb begin
        logic w_found;
        int   idx;
        w_gnt   = '0;
        w_win   = r_last;
        w_found = 1'b0;
        idx     = 0;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(r_last) + off) % N;
            if (!w_found && req[idx]) begin
                w_found    = 1'b1;
                w_gnt[idx] = 1'b1;
                w_win      = IDX_W'(idx);
            end else begin
                w_found = w_found;
            end
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= IDX_W'(N - 1);
        end else if (advance) begin
            r_last <= w_win;
        end else begin
            r_last <= r_last;
        end
    end

    assign gnt = w_gnt;

endmodule

// File: rtl/credit_bp_tx.sv
// Credit-based VC transmitter: per-VC credit counters with round-robin selection
// of one flit per cycle. The selected flit reaches the link one cycle later.
module credit_bp_tx
    import common_pkg::*;
#(
    parameter int VC_W  = DEFAULT_VC_W,
    parameter int D_W   = DEFAULT_D_W,
    parameter int A_W   = DEFAULT_A_W,
    parameter int DEPTH = DEFAULT_VC_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    noc_if.transmitter                  to_rx,
    input  logic [VC_W-1:0]             i_v,
    input  logic [VC_W*(A_W+D_W+1)-1:0] i_d,
    output logic [VC_W-1:0]             o_b
);

    localparam int FW    = flit_w(A_W, D_W);
    localparam int CNT_W = $clog2(DEPTH);

    logic [VC_W-1:0]       w_elig;
    logic [VC_W-1:0]       w_gnt;
    logic [VC_W*CNT_W-1:0] w_cnt;
    logic [FW-1:0]         w_sel;
    logic [VC_W-1:0]       r_target;
    logic [FW-1:0]         r_packet;

    for (genvar ii = 0; ii < VC_W; ii++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;

        // Credit counter: a send consumes a credit and a returned grant restores one.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= CNT_W'(DEPTH - 1);
            end else begin
                case ({w_gnt[ii], to_rx.credit_vc_credit_gnt[ii]})
                    2'b10:   r_cnt <= r_cnt - CNT_W'(1);
                    2'b01:   r_cnt <= r_cnt + CNT_W'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

        // Eligibility uses the registered count only; a same-cycle grant does not count.
        assign w_elig[ii]                 = i_v[ii] & (r_cnt != CNT_W'(0)) & ~rst;
        assign w_cnt[ii*CNT_W +: CNT_W]   = r_cnt;
    end

    rr_arbiter #(
        .N (VC_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (w_elig),
        .advance (|w_gnt),
        .gnt     (w_gnt)
    );

    // Mux the winning VC's flit.
    always_comb begin
        w_sel = '0;
        for (int ii = 0; ii < VC_W; ii++) begin
            if (w_gnt[ii]) begin
                w_sel = w_sel | i_d[ii*FW +: FW];
            end else begin
                w_sel = w_sel;
            end
        end
    end

    // Link register: the target pulses for one cycle and the packet holds between sends.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_target <= '0;
            r_packet <= '0;
        end else begin
            r_target <= w_gnt;
            if (|w_gnt) begin
                r_packet <= w_sel;
            end else begin
                r_packet <= r_packet;
            end
        end
    end

    assign o_b                    = ~w_gnt;
    assign to_rx.credit_vc_target = r_target;
    assign to_rx.credit_packet    = r_packet;

    credit_bp_tx_chk #(
        .VC_W  (VC_W),
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) u_chk (
        .clk    (clk),
        .rst    (rst),
        .acc    (w_gnt),
        .gnt    (to_rx.credit_vc_credit_gnt),
        .cnt    (w_cnt),
        .target (r_target),
        .o_b    (o_b)
    );

endmodule

// File: tb/tb_credit_bp_tx.sv
// Randomized plus directed bench for credit_bp_tx.
// It compares the DUT against a credit/round-robin reference model kept in the bench.
module tb_credit_bp_tx;

    localparam int VC_W  = 2;
    localparam int D_W   = 8;
    localparam int A_W   = 4;
    localparam int DEPTH = 4;
    localparam int FW    = A_W + D_W + 1;

    logic               clk;
    logic               rst;
    logic [VC_W-1:0]    i_v;
    logic [VC_W*FW-1:0] i_d;
    logic [VC_W-1:0]    o_b;

    int n_vec;
    int n_err;

    int             m_cnt [VC_W];
    int             m_ptr;
    logic [VC_W-1:0] m_tgt;
    logic [FW-1:0]   m_pkt;

    noc_if #(.VC_W(VC_W), .A_W(A_W), .D_W(D_W)) u_if ();

    credit_bp_tx #(
        .VC_W  (VC_W),
        .D_W   (D_W),
        .A_W   (A_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .to_rx (u_if),
        .i_v   (i_v),
        .i_d   (i_d),
        .o_b   (o_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One cycle. Grants are only issued for credits that are actually outstanding.
    task automatic step(input logic r, input logic [VC_W-1:0] v, input logic [VC_W-1:0] g_req);
        logic [VC_W-1:0] g;
        logic [VC_W-1:0] exp_ob;
        int              win;
        int              idx;
        @(negedge clk);
        g = '0;
        for (int ii = 0; ii < VC_W; ii++)
            if (!r && g_req[ii] && m_cnt[ii] < DEPTH - 1) g[ii] = 1'b1;
        rst = r;
        i_v = v;
        i_d = (VC_W*FW)'({$urandom, $urandom});
        u_if.credit_vc_credit_gnt = g;
        win = -1;
        if (!r) begin
            for (int off = 1; off <= VC_W; off++) begin
                idx = (m_ptr + off) % VC_W;
                if (win < 0 && v[idx] && m_cnt[idx] > 0) win = idx;
            end
        end
        exp_ob = '1;
        if (win >= 0) exp_ob[win] = 1'b0;
        #1;
        check_eq("o_b", 64'(o_b), 64'(exp_ob));
        @(posedge clk);
        #1;
        if (r) begin
            for (int ii = 0; ii < VC_W; ii++) m_cnt[ii] = DEPTH - 1;
            m_ptr = VC_W - 1;
            m_tgt = '0;
            m_pkt = '0;
        end else begin
            for (int ii = 0; ii < VC_W; ii++)
                m_cnt[ii] = m_cnt[ii] + int'(g[ii]) - ((win == ii) ? 1 : 0);
            m_tgt = '0;
            if (win >= 0) begin
                m_tgt[win] = 1'b1;
                m_pkt      = i_d[win*FW +: FW];
                m_ptr      = win;
            end
        end
        check_eq("credit_vc_target", 64'(u_if.credit_vc_target), 64'(m_tgt));
        check_eq("credit_packet", 64'(u_if.credit_packet), 64'(m_pkt));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        i_v   = '0;
        i_d   = '0;
        u_if.credit_vc_credit_gnt = '0;
        for (int ii = 0; ii < VC_W; ii++) m_cnt[ii] = DEPTH - 1;
        m_ptr = VC_W - 1;
        m_tgt = '0;
        m_pkt = '0;

        step(1'b1, 2'b11, 2'b00);
        step(1'b1, 2'b11, 2'b00);

        // Fill VC0: three accepts, then a stall.
        for (int k = 0; k < 4; k++) step(1'b0, 2'b01, 2'b00);
        // Refill with one grant, then accept.
        step(1'b0, 2'b00, 2'b01);
        step(1'b0, 2'b01, 2'b00);
        // Simultaneous accept and grant at count 1.
        step(1'b0, 2'b00, 2'b01);
        step(1'b0, 2'b01, 2'b01);
        step(1'b0, 2'b01, 2'b00);
        step(1'b0, 2'b01, 2'b00);
        // Isolation: VC0 is starved and VC1 drains its credits.
        for (int k = 0; k < 5; k++) step(1'b0, 2'b11, 2'b00);
        // Fairness with credits replenished every cycle.
        step(1'b0, 2'b00, 2'b11);
        for (int k = 0; k < 8; k++) step(1'b0, 2'b11, 2'b11);
        // Reset mid-burst; VC0 is served first afterwards.
        step(1'b1, 2'b11, 2'b00);
        step(1'b0, 2'b11, 2'b00);
        step(1'b0, 2'b11, 2'b00);

        for (int k = 0; k < 400; k++)
            step(($urandom_range(0, 63) == 0), 2'($urandom), 2'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
